// File: rtl/pwm_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_arbiter
// Description : Two-requester round-robin write arbiter for the PWM /
//               output-enable configuration bank. Accepted writes land in
//               shadow registers. The shadow bank is copied to the active
//               bank at a PWM period boundary (only if something changed)
//               or on an explicit commit_now pulse, so outputs never change
//               mid-period. Also owns the PWM prescaler and the 8-bit period
//               counter.
// Ports       :
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/addr/data/ready    requester N write channel (N = 0, 1)
//   commit_now                    force a shadow->active copy this cycle
//   en_reg_* / pwm_duty_cycle     active configuration registers
//   pwm_cnt                       PWM period counter
//   period_end                    pulse on the last clk of a PWM period
//   commit_pending                shadow differs from the last commit
//   bad_addr                      pulse when an accepted write is out of map
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_arbiter #(
    parameter int PWM_DIV = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       commit_now,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic [7:0] pwm_cnt,
    output logic       period_end,
    output logic       commit_pending,
    output logic       bad_addr
);

    localparam int             NUM_REGS = 5;
    localparam int             DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);
    localparam logic [6:0]     MAX_ADDR = 7'(NUM_REGS - 1);

    logic             last_q, last_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic             dirty_q, dirty_d;
    logic [7:0]       shadow_q [NUM_REGS];
    logic [7:0]       shadow_d [NUM_REGS];
    logic [7:0]       active_q [NUM_REGS];
    logic [7:0]       active_d [NUM_REGS];

    logic             grant0;
    logic             grant1;
    logic             wr_en;
    logic [6:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             addr_ok;
    logic             tick;
    logic             commit;

    // ------------------------------------------------------------------
    // Arbitration. Gated by rst_n so both grants are low while reset is
    // asserted, which also drops any write that was in flight.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                // Contention: the requester not granted last time wins.
                if (last_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wr_en      = grant0 | grant1;
    assign wr_addr    = grant1 ? req1_addr : req0_addr;
    assign wr_data    = grant1 ? req1_data : req0_data;
    assign addr_ok    = (wr_addr <= MAX_ADDR);
    assign bad_addr   = wr_en && !addr_ok;

    // ------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------
    assign tick       = (div_cnt_q == DIV_MAX);
    assign period_end = tick && (pwm_cnt_q == 8'hFF);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    // A commit copies the shadow values as they were before any write
    // accepted this same cycle; that write then leaves dirty set.
    assign commit = (period_end && dirty_q) || commit_now;

    always_comb begin
        last_d  = last_q;
        dirty_d = dirty_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = commit ? shadow_q[i] : active_q[i];
        end

        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end

        if (commit) begin
            dirty_d = 1'b0;
        end

        if (wr_en && addr_ok) begin
            dirty_d = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == 7'(i)) begin
                    shadow_d[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            dirty_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            last_q    <= last_d;
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            dirty_q   <= dirty_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign en_reg_out_7_0  = active_q[0];
    assign en_reg_out_15_8 = active_q[1];
    assign en_reg_pwm_7_0  = active_q[2];
    assign en_reg_pwm_15_8 = active_q[3];
    assign pwm_duty_cycle  = active_q[4];
    assign pwm_cnt         = pwm_cnt_q;
    assign commit_pending  = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_cfg_arbiter
// Description : Randomized scoreboard bench for pwm_cfg_arbiter. The driver
//               predicts each grant and queues it; the monitor pops on every
//               observed handshake and keeps a register-bank model to check
//               the active outputs, dirty flag, counter and period pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_cfg_arbiter;

    localparam int DIV = 2;
    localparam int PER = 256 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [6:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       commit_now;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle, pwm_cnt;
    logic       period_end, commit_pending, bad_addr;

    always #5 clk = ~clk;

    pwm_cfg_arbiter #(.PWM_DIV(DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .commit_now     (commit_now),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .pwm_cnt        (pwm_cnt),
        .period_end     (period_end),
        .commit_pending (commit_pending),
        .bad_addr       (bad_addr)
    );

    typedef struct {
        int         who;
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    logic [7:0] act_dut [5];
    assign act_dut[0] = en_reg_out_7_0;
    assign act_dut[1] = en_reg_out_15_8;
    assign act_dut[2] = en_reg_pwm_7_0;
    assign act_dut[3] = en_reg_pwm_15_8;
    assign act_dut[4] = pwm_duty_cycle;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor with register-bank reference model
    // ------------------------------------------------------------------
    logic [7:0] m_shadow [5];
    logic [7:0] m_active [5];
    bit         m_dirty;
    int         cyc;
    wr_t        it;
    bit         pe_exp;
    bit         do_commit;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", int'(req0_ready), 0);
            chk("rst_ready1", int'(req1_ready), 0);
            chk("rst_period_end", int'(period_end), 0);
            chk("rst_bad_addr", int'(bad_addr), 0);
            chk("rst_pending", int'(commit_pending), 0);
            chk("rst_pwm_cnt", int'(pwm_cnt), 0);
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rst_active%0d", i), int'(act_dut[i]), 0);
                m_shadow[i] = 8'h00;
                m_active[i] = 8'h00;
            end
            m_dirty = 1'b0;
            cyc     = 0;
            exp_q.delete();
        end else begin
            pe_exp = ((cyc % PER) == PER - 1);
            chk("pwm_cnt", int'(pwm_cnt), (cyc / DIV) % 256);
            chk("period_end", int'(period_end), int'(pe_exp));
            chk("commit_pending", int'(commit_pending), int'(m_dirty));
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("active%0d", i), int'(act_dut[i]), int'(m_active[i]));
            end

            // Commit sees the shadow bank before this cycle's write.
            do_commit = (pe_exp && m_dirty) || commit_now;
            if (do_commit) begin
                for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
                m_dirty = 1'b0;
            end

            if (req0_ready || req1_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got ready0=%0b ready1=%0b expected none at %0t",
                             req0_ready, req1_ready, $time);
                end else begin
                    it = exp_q.pop_front();
                    chk("grant_both", int'(req0_ready && req1_ready), 0);
                    chk("grant_who", req1_ready ? 1 : 0, it.who);
                    chk("bad_addr", int'(bad_addr), (it.addr > 7'd4) ? 1 : 0);
                    if (it.addr <= 7'd4) begin
                        m_shadow[it.addr] = it.data;
                        m_dirty           = 1'b1;
                    end
                end
            end else begin
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_grant: got no ready expected requester %0d at %0t",
                             it.who, $time);
                end
                chk("bad_addr_idle", int'(bad_addr), 0);
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Driver: random requests with hold-while-not-granted behaviour
    // ------------------------------------------------------------------
    bit last_m;   // requester granted most recently
    bit h0, h1;   // request left pending last cycle, must be held

    function automatic logic [6:0] rand_addr();
        logic [6:0] a;
        if ($urandom_range(0, 7) == 0) a = 7'($urandom_range(5, 127));
        else                           a = 7'($urandom_range(0, 4));
        return a;
    endfunction

    task automatic drive_step(input bit force_both);
        int  who;
        bit  g0, g1;
        wr_t w;
        if (!h0) begin
            req0_valid = force_both || ($urandom_range(0, 1) == 1);
            req0_addr  = force_both ? 7'd0  : rand_addr();
            req0_data  = force_both ? 8'hAA : 8'($urandom_range(0, 255));
        end
        if (!h1) begin
            req1_valid = force_both || ($urandom_range(0, 1) == 1);
            req1_addr  = force_both ? 7'd1  : rand_addr();
            req1_data  = force_both ? 8'h55 : 8'($urandom_range(0, 255));
        end
        commit_now = ($urandom_range(0, 99) == 0);

        who = -1;
        if (req0_valid && req1_valid) who = last_m ? 0 : 1;
        else if (req0_valid)          who = 0;
        else if (req1_valid)          who = 1;

        g0 = (who == 0);
        g1 = (who == 1);
        if (who >= 0) begin
            w.who  = who;
            w.addr = (who == 1) ? req1_addr : req0_addr;
            w.data = (who == 1) ? req1_data : req0_data;
            exp_q.push_back(w);
            last_m = (who == 1);
        end
        h0 = req0_valid && !g0;
        h1 = req1_valid && !g1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        commit_now = 1'b0;
        h0 = 1'b0;
        h1 = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_addr  = '0;
        req1_data  = '0;
        idle_inputs();
        last_m = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Opening contention: requester 0 must win first.
        for (int k = 0; k < 4; k++) begin
            drive_step(1'b1);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 1800; k++) begin
            drive_step(1'b0);
            @(posedge clk);
            #1;
        end

        // Held contention, then reset mid-transfer.
        for (int k = 0; k < 3; k++) begin
            drive_step(1'b1);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        last_m = 1'b1;
        h0 = 1'b0;
        h1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            drive_step(1'b1);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 1300; k++) begin
            drive_step(1'b0);
            @(posedge clk);
            #1;
        end

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
